// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared definitions for the raster timing generator:
//   - video_id_code_e : CEA format codes, the same values the pixel-clock stage uses
//   - vga_timing_t    : horizontal/vertical timing for one format plus sync polarity
//   - get_timing()    : format code -> timing record
//   - COLOUR_* / COLOUR_BARS : test-pattern bar colours, {r,g,b}, left to right
package vga_timing_pkg;

    typedef enum int {
        VIC_640X480P60      = 1,
        VIC_720X480P60_4_3  = 2,
        VIC_720X480P60_16_9 = 3,
        VIC_1280X720P60     = 4
    } video_id_code_e;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
        logic        sync_pos;   // 1 = sync pulses are high
    } vga_timing_t;

    function automatic bit is_valid_code(int code);
        return (code >= int'(VIC_640X480P60)) && (code <= int'(VIC_1280X720P60));
    endfunction

    function automatic vga_timing_t get_timing(int code);
        vga_timing_t t;
        case (code)
            VIC_720X480P60_4_3,
            VIC_720X480P60_16_9: t = '{720, 16, 62, 60, 480, 9, 6, 30, 1'b0};
            VIC_1280X720P60:     t = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1};
            default:             t = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
        endcase
        return t;
    endfunction

    localparam logic [23:0] COLOUR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] COLOUR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] COLOUR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] COLOUR_GREEN   = 24'h00FF00;
    localparam logic [23:0] COLOUR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] COLOUR_RED     = 24'hFF0000;
    localparam logic [23:0] COLOUR_BLUE    = 24'h0000FF;
    localparam logic [23:0] COLOUR_BLACK   = 24'h000000;

    // Element 0 is the leftmost bar.
    localparam logic [7:0][23:0] COLOUR_BARS = {
        COLOUR_BLACK, COLOUR_BLUE, COLOUR_RED, COLOUR_MAGENTA,
        COLOUR_GREEN, COLOUR_CYAN, COLOUR_YELLOW, COLOUR_WHITE
    };

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One raster axis: a wrapping position counter with registered active and
// sync flags decoded from the next count, so flags change on the same edge
// as the count.
//   clk_pixel : pixel clock
//   reset     : asynchronous, active-high; count parks at TOTAL-1
//   step      : advance one position this clock
//   count     : current position
//   active    : count < ACTIVE
//   sync      : sync pulse at POS_POL polarity
//   wrap      : combinational, high when this step takes count back to 0
module vga_axis_counter #(
    parameter int unsigned ACTIVE  = 640,
    parameter int unsigned FP      = 16,
    parameter int unsigned SYNC    = 96,
    parameter int unsigned BP      = 48,
    parameter logic        POS_POL = 1'b0,
    parameter int unsigned W       = 11
) (
    input  logic         clk_pixel,
    input  logic         reset,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         active,
    output logic         sync,
    output logic         wrap
);

    localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam int unsigned SYNC_START = ACTIVE + FP;
    localparam int unsigned SYNC_END   = SYNC_START + SYNC;

    logic [W-1:0] next;

    assign wrap = step && (count == W'(TOTAL - 1));

    always_comb begin
        next = count;
        if (wrap)
            next = '0;
        else if (step)
            next = count + 1'b1;
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            count  <= W'(TOTAL - 1);
            active <= 1'b0;
            sync   <= ~POS_POL;
        end else begin
            count  <= next;
            active <= (next < W'(ACTIVE));
            sync   <= ((next >= W'(SYNC_START)) && (next < W'(SYNC_END))) ? POS_POL : ~POS_POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator for the CEA formats selected by VIDEO_ID_CODE
// (1 = 640x480p60, 2/3 = 720x480p60, 4 = 1280x720p60).
//   clk_pixel   : pixel clock from the clock stage
//   reset       : asynchronous, active-high
//   enable      : advance the raster (tie to MMCM locked)
//   cx, cy      : current position
//   hsync/vsync : sync at format polarity
//   de          : active-video enable
//   line_start  : pulse at cx==0
//   frame_start : pulse at cx==0, cy==0
//   rgb         : colour-bar test pattern, only with VGA_TIMING_TEST_PATTERN_EN
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int VIDEO_ID_CODE = 4,
    parameter int CX_W          = 11,
    parameter int CY_W          = 10
) (
    input  logic            clk_pixel,
    input  logic            reset,
    input  logic            enable,
    output logic [CX_W-1:0] cx,
    output logic [CY_W-1:0] cy,
    output logic            hsync,
    output logic            vsync,
    output logic            de,
    output logic            line_start,
    output logic            frame_start
`ifdef VGA_TIMING_TEST_PATTERN_EN
    ,
    output logic [23:0]     rgb
`endif
);

    localparam vga_timing_t T = get_timing(VIDEO_ID_CODE);

    if (!is_valid_code(VIDEO_ID_CODE)) begin : g_bad_code
        $error("vga_timing_gen: unsupported VIDEO_ID_CODE %0d", VIDEO_ID_CODE);
    end

    logic h_active, v_active, h_wrap, v_wrap, en_q;

    vga_axis_counter #(
        .ACTIVE (T.h_active), .FP(T.h_fp), .SYNC(T.h_sync), .BP(T.h_bp),
        .POS_POL(T.sync_pos), .W(CX_W)
    ) u_h_axis (
        .clk_pixel(clk_pixel), .reset(reset), .step(enable),
        .count(cx), .active(h_active), .sync(hsync), .wrap(h_wrap)
    );

    // The vertical axis steps only on horizontal wrap, so vsync edges land on cx==0.
    vga_axis_counter #(
        .ACTIVE (T.v_active), .FP(T.v_fp), .SYNC(T.v_sync), .BP(T.v_bp),
        .POS_POL(T.sync_pos), .W(CY_W)
    ) u_v_axis (
        .clk_pixel(clk_pixel), .reset(reset), .step(h_wrap),
        .count(cy), .active(v_active), .sync(vsync), .wrap(v_wrap)
    );

    // Wrap is asserted on the edge that lands on position 0, so registering it
    // gives pulses aligned with cx==0. en_q gates de off after a disabled edge.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            en_q        <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            en_q        <= enable;
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

    // All three terms are flops updated on the same edge as cx/cy.
    assign de = h_active & v_active & en_q;

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int unsigned BAR_W = T.h_active / 8;

    logic [CX_W-1:0] h_next;
    logic [CY_W-1:0] v_next;
    logic [2:0]      bar_idx;

    // Next position, so the registered colour lines up with the counters.
    always_comb begin
        h_next = cx;
        if (h_wrap)
            h_next = '0;
        else if (enable)
            h_next = cx + 1'b1;
        v_next = cy;
        if (v_wrap)
            v_next = '0;
        else if (h_wrap)
            v_next = cy + 1'b1;
        bar_idx = 3'(h_next / CX_W'(BAR_W));
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset)
            rgb <= '0;
        else if (enable && (h_next < CX_W'(T.h_active)) && (v_next < CY_W'(T.v_active)))
            rgb <= COLOUR_BARS[bar_idx];
        else
            rgb <= '0;
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Three generators (codes 1, 2, 4) share clock, reset and enable. A position
// model derived from the count of enabled edges since reset predicts every
// output each cycle; directed checks pin reset values, sync windows, line
// length, the enable pause and a mid-line reset.
module tb_vga_timing_gen;

    logic clk_pixel = 1'b0;
    logic reset     = 1'b0;
    logic enable    = 1'b0;

    always #5 clk_pixel = ~clk_pixel;

    logic [10:0] cx [3];
    logic [9:0]  cy [3];
    logic        hs [3];
    logic        vs [3];
    logic        de [3];
    logic        ls [3];
    logic        fs [3];
`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [23:0] rgb [3];
`endif

    vga_timing_gen #(.VIDEO_ID_CODE(1), .CX_W(11), .CY_W(10)) u_fmt1 (
        .clk_pixel(clk_pixel), .reset(reset), .enable(enable),
        .cx(cx[0]), .cy(cy[0]), .hsync(hs[0]), .vsync(vs[0]), .de(de[0]),
        .line_start(ls[0]), .frame_start(fs[0])
`ifdef VGA_TIMING_TEST_PATTERN_EN
        , .rgb(rgb[0])
`endif
    );

    vga_timing_gen #(.VIDEO_ID_CODE(2), .CX_W(11), .CY_W(10)) u_fmt2 (
        .clk_pixel(clk_pixel), .reset(reset), .enable(enable),
        .cx(cx[1]), .cy(cy[1]), .hsync(hs[1]), .vsync(vs[1]), .de(de[1]),
        .line_start(ls[1]), .frame_start(fs[1])
`ifdef VGA_TIMING_TEST_PATTERN_EN
        , .rgb(rgb[1])
`endif
    );

    vga_timing_gen #(.VIDEO_ID_CODE(4), .CX_W(11), .CY_W(10)) u_fmt4 (
        .clk_pixel(clk_pixel), .reset(reset), .enable(enable),
        .cx(cx[2]), .cy(cy[2]), .hsync(hs[2]), .vsync(vs[2]), .de(de[2]),
        .line_start(ls[2]), .frame_start(fs[2])
`ifdef VGA_TIMING_TEST_PATTERN_EN
        , .rgb(rgb[2])
`endif
    );

    // Format table, index 0 = code 1, 1 = code 2, 2 = code 4.
    localparam int HA [3] = '{640, 720, 1280};
    localparam int HF [3] = '{16, 16, 110};
    localparam int HS [3] = '{96, 62, 40};
    localparam int HB [3] = '{48, 60, 220};
    localparam int VA [3] = '{480, 480, 720};
    localparam int VF [3] = '{10, 9, 5};
    localparam int VS [3] = '{2, 6, 5};
    localparam int VB [3] = '{33, 30, 20};
    localparam bit POS[3] = '{1'b0, 1'b0, 1'b1};
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Position after n enabled edges: n==0 is the reset park at (HT-1, VT-1),
    // otherwise the raster index is n-1 modulo the frame size.
    function automatic void model(input int k, input longint n, input bit en,
                                  output logic [25:0] vec, output logic [23:0] col);
        int ht, vt, x, y;
        longint p;
        logic h, v, d, l, f;
        ht = HA[k] + HF[k] + HS[k] + HB[k];
        vt = VA[k] + VF[k] + VS[k] + VB[k];
        if (n == 0) begin
            x = ht - 1;
            y = vt - 1;
        end else begin
            p = (n - 1) % (longint'(ht) * vt);
            x = int'(p % ht);
            y = int'(p / ht);
        end
        h = (x >= HA[k] + HF[k] && x < HA[k] + HF[k] + HS[k]) ? POS[k] : !POS[k];
        v = (y >= VA[k] + VF[k] && y < VA[k] + VF[k] + VS[k]) ? POS[k] : !POS[k];
        d = en && (x < HA[k]) && (y < VA[k]);
        l = en && (x == 0);
        f = l && (y == 0);
        vec = {11'(x), 10'(y), h, v, d, l, f};
        col = d ? BARS[x / (HA[k] / 8)] : 24'h0;
    endfunction

    longint n_en;
    bit     en_last;

    always @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            n_en    <= 0;
            en_last <= 1'b0;
        end else begin
            if (enable) n_en <= n_en + 1;
            en_last <= enable;
        end
    end

    always @(negedge clk_pixel) begin
        if (run_cmp) begin
            for (int k = 0; k < 3; k++) begin
                logic [25:0] ev;
                logic [23:0] ec;
                model(k, n_en, en_last, ev, ec);
                check($sformatf("model_k%0d {cx,cy,hs,vs,de,ls,fs}", k),
                      {cx[k], cy[k], hs[k], vs[k], de[k], ls[k], fs[k]}, ev);
`ifdef VGA_TIMING_TEST_PATTERN_EN
                check($sformatf("model_k%0d rgb", k), rgb[k], ec);
`endif
            end
        end
    end

    task automatic wait_cx(input int tx, input int ty, input int budget);
        int c = 0;
        while (!(cx[0] == 11'(tx) && (ty < 0 || cy[0] == 10'(ty))) && c < budget) begin
            @(negedge clk_pixel);
            c++;
        end
        check($sformatf("reach cx=%0d cy=%0d", tx, ty), (c < budget), 1);
    endtask

    int h1, d1, h4, d4;

    initial begin
        #2 reset = 1'b1;
        repeat (3) @(negedge clk_pixel);
        check("rst cx1", cx[0], 799);
        check("rst cy1", cy[0], 524);
        check("rst hs1", hs[0], 1);
        check("rst vs1", vs[0], 1);
        check("rst de1", {de[0], ls[0], fs[0]}, 0);
        check("rst cx2", cx[1], 857);
        check("rst cy2", cy[1], 524);
        check("rst cx4", cx[2], 1649);
        check("rst cy4", cy[2], 749);
        check("rst hs4/vs4", {hs[2], vs[2]}, 2'b00);
        run_cmp = 1'b1;
        reset   = 1'b0;
        enable  = 1'b1;

        h1 = 0; d1 = 0; h4 = 0; d4 = 0;
        for (int i = 0; i < 1650; i++) begin
            @(negedge clk_pixel);
            if (i < 800) begin
                if (!hs[0]) h1++;
                if (de[0])  d1++;
            end
            if (hs[2]) h4++;
            if (de[2]) d4++;
            case (i)
                0: for (int k = 0; k < 3; k++)
                       check($sformatf("first k%0d {cx,cy,de,ls,fs}", k),
                             {cx[k], cy[k], de[k], ls[k], fs[k]}, {21'd0, 3'b111});
                655:  check("hs1 cx655", hs[0], 1);
                656:  check("hs1 cx656", hs[0], 0);
                751:  check("hs1 cx751", hs[0], 0);
                752:  check("hs1 cx752", hs[0], 1);
                857:  check("cx2 end", cx[1], 857);
                858:  check("cx2 wrap {cx,cy,ls,fs}", {cx[1], cy[1], ls[1], fs[1]}, {11'd0, 10'd1, 2'b10});
                1389: check("hs4 cx1389", hs[2], 0);
                1390: check("hs4 cx1390", hs[2], 1);
                1429: check("hs4 cx1429", hs[2], 1);
                1430: check("hs4 cx1430", hs[2], 0);
                default: ;
            endcase
`ifdef VGA_TIMING_TEST_PATTERN_EN
            case (i)
                0:   check("rgb cx0", rgb[0], 24'hFFFFFF);
                80:  check("rgb cx80", rgb[0], 24'hFFFF00);
                639: check("rgb cx639", rgb[0], 24'h000000);
                640: check("rgb cx640", rgb[0], 24'h000000);
                default: ;
            endcase
`endif
        end
        check("hs1 low count", h1, 96);
        check("de1 count line0", d1, 640);
        check("hs4 high count", h4, 40);
        check("de4 count line0", d4, 1280);

        wait_cx(100, 50, 50000);
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_pixel);
            check("hold {cx,cy,de,ls}", {cx[0], cy[0], de[0], ls[0]}, {11'd100, 10'd50, 2'b00});
        end
        enable = 1'b1;
        @(negedge clk_pixel);
        check("resume {cx,cy,de}", {cx[0], cy[0], de[0]}, {11'd101, 10'd50, 1'b1});

        wait_cx(500, -1, 1000);
        reset = 1'b1;
        #1;
        check("midrst {cx,cy}", {cx[0], cy[0]}, {11'd799, 10'd524});
        check("midrst {hs,vs,de,ls,fs}", {hs[0], vs[0], de[0], ls[0], fs[0]}, 5'b11000);
        check("midrst cx4", cx[2], 1649);
        repeat (2) @(negedge clk_pixel);
        reset = 1'b0;
        @(negedge clk_pixel);
        check("post-rst {cx,cy,ls,fs,de}", {cx[0], cy[0], ls[0], fs[0], de[0]}, {21'd0, 3'b111});

        repeat (2000) @(negedge clk_pixel);
        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
